// File: rtl/frame_bank_scheduler.sv
// Ping-pong SRAM bank scheduler: swaps writer/reader banks only at frame boundaries.
// All outputs registered (1 cycle after the sampling edge); the writer is stalled via wr_enable while a finished frame awaits display.
module frame_bank_scheduler #(
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int DROP_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_start,
  input  logic              wr_frame_end,
  input  logic              rd_frame_start,
  input  logic              freeze,
  output logic              sram_flag,
  output logic              wr_enable,
  output logic              swap_pulse,
  output logic [DROP_W-1:0] frames_dropped,
  output logic              timeout_flag,
  output logic [1:0]        state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PEND  = 2'd2
  } st_t;

  st_t              st;
  logic [CNT_W-1:0] tcnt;
  logic [1:0]       drop_inc;
  logic [DROP_W:0]  drop_sum;
  logic [DROP_W-1:0] drop_next;

  assign state = st;

  // A start+end pair under freeze discards two frames in one cycle, hence a 2-bit increment.
  always_comb begin
    drop_inc = 2'd0;
    case (st)
      WRITE:   drop_inc = {1'b0, wr_frame_start} + {1'b0, wr_frame_end & freeze};
      PEND:    if (wr_frame_start && !rd_frame_start) drop_inc = 2'd1;
      default: drop_inc = 2'd0;
    endcase
  end

  assign drop_sum  = {1'b0, frames_dropped} + (DROP_W+1)'(drop_inc);
  assign drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st             <= IDLE;
      tcnt           <= '0;
      sram_flag      <= 1'b0;
      wr_enable      <= 1'b0;
      swap_pulse     <= 1'b0;
      frames_dropped <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      swap_pulse     <= 1'b0;
      frames_dropped <= drop_next;
      case (st)
        IDLE: begin
          if (wr_frame_start) begin
            st        <= WRITE;
            wr_enable <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_frame_end) begin
            wr_enable <= 1'b0;
            tcnt      <= '0;
            st        <= freeze ? IDLE : PEND;
          end
        end
        PEND: begin
          // A reader frame start wins over a coincident timeout: it is a normal swap.
          if (rd_frame_start) begin
            sram_flag    <= ~sram_flag;
            swap_pulse   <= 1'b1;
            timeout_flag <= 1'b0;
            tcnt         <= '0;
            if (wr_frame_start) begin
              st        <= WRITE;
              wr_enable <= 1'b1;
            end else begin
              st <= IDLE;
            end
          end else if (tcnt == TO_LAST) begin
            sram_flag    <= ~sram_flag;
            swap_pulse   <= 1'b1;
            timeout_flag <= 1'b1;
            tcnt         <= '0;
            st           <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          st        <= IDLE;
          wr_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler with a short timeout and a 3-bit drop counter.
module tb_frame_bank_scheduler;

  logic       clk;
  logic       rst;
  logic       wr_frame_start;
  logic       wr_frame_end;
  logic       rd_frame_start;
  logic       freeze;
  logic       sram_flag;
  logic       wr_enable;
  logic       swap_pulse;
  logic [2:0] frames_dropped;
  logic       timeout_flag;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  frame_bank_scheduler #(.TIMEOUT_CYCLES(50), .DROP_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_frame_start (wr_frame_start),
    .wr_frame_end   (wr_frame_end),
    .rd_frame_start (rd_frame_start),
    .freeze         (freeze),
    .sram_flag      (sram_flag),
    .wr_enable      (wr_enable),
    .swap_pulse     (swap_pulse),
    .frames_dropped (frames_dropped),
    .timeout_flag   (timeout_flag),
    .state          (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_frame_start = 1'b0;
    wr_frame_end   = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all(input string tag, input logic s_flag, input logic wen, input logic sw,
                         input logic [2:0] drops, input logic tflag, input logic [1:0] st);
    chk({tag, ".sram_flag"}, 32'(sram_flag), 32'(s_flag));
    chk({tag, ".wr_enable"}, 32'(wr_enable), 32'(wen));
    chk({tag, ".swap_pulse"}, 32'(swap_pulse), 32'(sw));
    chk({tag, ".dropped"}, 32'(frames_dropped), 32'(drops));
    chk({tag, ".timeout"}, 32'(timeout_flag), 32'(tflag));
    chk({tag, ".state"}, 32'(state), 32'(st));
  endtask

  initial begin
    rst            = 1'b1;
    wr_frame_start = 1'b0;
    wr_frame_end   = 1'b0;
    rd_frame_start = 1'b0;
    freeze         = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("reset", 0, 0, 0, 3'd0, 0, 2'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic swap: start, 89 write cycles, end, reader start 50 cycles later
    idle(9);
    wr_frame_start = 1'b1; tick();
    chk_all("basic.write", 0, 1, 0, 3'd0, 0, 2'd1);
    idle(89);
    chk("basic.mid_wen", 32'(wr_enable), 32'd1);
    wr_frame_end = 1'b1; tick();
    chk_all("basic.pend", 0, 0, 0, 3'd0, 0, 2'd2);
    idle(49);
    chk_all("basic.pend_late", 0, 0, 0, 3'd0, 0, 2'd2);
    // Reader start lands on the timeout edge: must be a normal swap
    rd_frame_start = 1'b1; tick();
    chk_all("basic.swap", 1, 0, 1, 3'd0, 0, 2'd0);
    tick();
    chk("basic.pulse_once", 32'(swap_pulse), 32'd0);
    chk("basic.flag_hold", 32'(sram_flag), 32'd1);

    // Writer faster than reader: three starts while pending
    wr_frame_start = 1'b1; tick();
    wr_frame_end = 1'b1; tick();
    chk("fast.pend", 32'(state), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      wr_frame_start = 1'b1; tick();
      chk_all($sformatf("fast.drop%0d", i), 1, 0, 0, 3'(i), 0, 2'd2);
      tick();
    end
    rd_frame_start = 1'b1; tick();
    chk_all("fast.swap", 0, 0, 1, 3'd3, 0, 2'd0);

    // Coincident reader start and writer start in PEND
    wr_frame_start = 1'b1; tick();
    wr_frame_end = 1'b1; tick();
    idle(2);
    rd_frame_start = 1'b1; wr_frame_start = 1'b1; tick();
    chk_all("coinc.swap", 1, 1, 1, 3'd3, 0, 2'd1);

    // Freeze at frame end: discard, then a clean frame swaps normally
    freeze = 1'b1;
    wr_frame_end = 1'b1; tick();
    chk_all("freeze.drop", 1, 0, 0, 3'd4, 0, 2'd0);
    freeze = 1'b0;
    wr_frame_start = 1'b1; tick();
    wr_frame_end = 1'b1; tick();
    chk("freeze.pend", 32'(state), 32'd2);
    idle(3);
    rd_frame_start = 1'b1; tick();
    chk_all("freeze.swap", 0, 0, 1, 3'd4, 0, 2'd0);

    // Timeout: forced swap exactly 50 cycles after PEND entry
    wr_frame_start = 1'b1; tick();
    wr_frame_end = 1'b1; tick();
    idle(49);
    chk_all("tmo.before", 0, 0, 0, 3'd4, 0, 2'd2);
    tick();
    chk_all("tmo.swap", 1, 0, 1, 3'd4, 1, 2'd0);

    // Missed end, then start+end together; timeout flag cleared by next normal swap
    wr_frame_start = 1'b1; tick();
    wr_frame_start = 1'b1; tick();
    chk_all("restart", 1, 1, 0, 3'd5, 1, 2'd1);
    wr_frame_start = 1'b1; wr_frame_end = 1'b1; tick();
    chk_all("start_end", 1, 0, 0, 3'd6, 1, 2'd2);
    rd_frame_start = 1'b1; tick();
    chk_all("tmo.clear", 0, 0, 1, 3'd6, 0, 2'd0);

    // Saturation: frozen start+end adds two drops, 6+2 holds at 7
    wr_frame_start = 1'b1; tick();
    freeze = 1'b1;
    wr_frame_start = 1'b1; wr_frame_end = 1'b1; tick();
    freeze = 1'b0;
    chk_all("sat.freeze", 0, 0, 0, 3'd7, 0, 2'd0);
    wr_frame_start = 1'b1; tick();
    wr_frame_start = 1'b1; tick();
    chk("sat.hold", 32'(frames_dropped), 32'd7);
    wr_frame_end = 1'b1; tick();
    rd_frame_start = 1'b1; tick();
    chk("sat.swap", 32'(sram_flag), 32'd1);

    // Reset in the middle of PEND with sram_flag high
    wr_frame_start = 1'b1; tick();
    wr_frame_end = 1'b1; tick();
    idle(2);
    chk("rstpend.pre", 32'({sram_flag, state}), 32'b110);
    #2 rst = 1'b0;
    #1 chk_all("rstpend.async", 0, 0, 0, 3'd0, 0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    rd_frame_start = 1'b1; tick();
    chk_all("rstpend.rd_only", 0, 0, 0, 3'd0, 0, 2'd0);
    wr_frame_start = 1'b1; tick();
    chk_all("rstpend.fresh", 0, 1, 0, 3'd0, 0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
